kernel_bc_vertex_packer: RTL

KERNEL_BC_VERTEX_PACKER -- requirements
Module: kernel_bc_vertex_packer

---
 rtl/kernel_bc_pkg.sv | 14 +
 rtl/kernel_bc_vertex_packer_oreg.sv | 41 ++++
 rtl/kernel_bc_vertex_packer.sv | 155 +++++++++++++++
 3 files changed

// File: rtl/kernel_bc_pkg.sv
// rtl/kernel_bc_pkg.sv - shared FSM encoding and defaults for the vertex packer
package kernel_bc_pkg;

  localparam int          DEF_LANES    = 16;
  localparam logic [31:0] DEF_SENTINEL = 32'hFFFF_FFFF;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PACK  = 2'd1,
    FLUSH = 2'd2,
    DONE  = 2'd3
  } state_t;

endpackage

// File: rtl/kernel_bc_vertex_packer_oreg.sv
// rtl/kernel_bc_vertex_packer_oreg.sv - output word register with hold/load handshake
module kernel_bc_vertex_packer_oreg
  import kernel_bc_pkg::*;
#(
  parameter int LANES = DEF_LANES
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  load,
  input  logic [32*LANES-1:0]   load_data,
  input  logic [LANES-1:0]      load_keep,
  input  logic                  load_last,
  input  logic                  ready,
  output logic [32*LANES-1:0]   data,
  output logic [LANES-1:0]      keep,
  output logic                  last,
  output logic                  valid,
  output logic                  free
);

  // A new word may replace the held one in the same cycle it is accepted.
  assign free = ~valid | ready;

  // Payload only changes on load, so it stays frozen while the consumer stalls.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data  <= '0;
      keep  <= '0;
      last  <= 1'b0;
      valid <= 1'b0;
    end else if (load) begin
      data  <= load_data;
      keep  <= load_keep;
      last  <= load_last;
      valid <= 1'b1;
    end else if (ready) begin
      valid <= 1'b0;
    end
  end

endmodule

// File: rtl/kernel_bc_vertex_packer.sv
// rtl/kernel_bc_vertex_packer.sv - packs a sentinel-terminated vertex ID stream into LANES-wide words
module kernel_bc_vertex_packer
  import kernel_bc_pkg::*;
#(
  parameter int          LANES    = DEF_LANES,
  parameter logic [31:0] SENTINEL = DEF_SENTINEL
) (
  input  logic                  ap_clk,
  input  logic                  ap_rst_n,
  input  logic                  ap_start,
  output logic                  ap_idle,
  output logic                  ap_done,
  input  logic                  in_empty_n,
  input  logic [31:0]           in_dout,
  output logic                  in_read,
  output logic [32*LANES-1:0]   out_data,
  output logic [LANES-1:0]      out_keep,
  output logic                  out_last,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [31:0]           vertex_count
);

  localparam int            LW        = (LANES > 1) ? $clog2(LANES) : 1;
  localparam logic [LW-1:0] LAST_LANE = LW'(LANES - 1);

  state_t               state;
  state_t               state_next;
  logic [LW-1:0]        lane_cnt;
  logic [32*LANES-1:0]  acc;
  logic [32*LANES-1:0]  acc_wr;
  logic [LANES-1:0]     keep_res;
  logic                 oreg_free;
  logic                 is_sentinel;
  logic                 word_end;
  logic                 stall;
  logic                 pop_id;
  logic                 load;
  logic [32*LANES-1:0]  load_data;
  logic [LANES-1:0]     load_keep;
  logic                 load_last;

  assign is_sentinel = (in_dout == SENTINEL);
  // A pop that would need the output register must wait for it to be free.
  assign word_end    = (lane_cnt == LAST_LANE) | is_sentinel;
  assign stall       = out_valid & ~out_ready & word_end;
  assign in_read     = in_empty_n & (state == PACK) & ~stall;
  assign pop_id      = in_read & ~is_sentinel;
  assign ap_idle     = (state == IDLE);
  assign ap_done     = (state == DONE);

  // Accumulator image with the incoming ID dropped into the current lane.
  always_comb begin
    acc_wr = acc;
    acc_wr[32*lane_cnt +: 32] = in_dout;
  end

  // Residual keep mask: one bit per lane already filled.
  always_comb begin
    keep_res = '0;
    for (int k = 0; k < LANES; k++) begin
      keep_res[k] = (k < int'(lane_cnt));
    end
  end

  // State register.
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state and output-register load decisions.
  always_comb begin
    state_next = state;
    load       = 1'b0;
    load_data  = acc_wr;
    load_keep  = '1;
    load_last  = 1'b0;
    case (state)
      IDLE: begin
        if (ap_start) state_next = PACK;
      end
      PACK: begin
        if (in_read) begin
          if (is_sentinel) begin
            state_next = FLUSH;
          end else if (lane_cnt == LAST_LANE) begin
            load = 1'b1;
          end
        end
      end
      FLUSH: begin
        // Once the last word is held, wait for its handshake; otherwise emit it.
        if (out_valid & out_last) begin
          if (out_ready) state_next = DONE;
        end else if (oreg_free) begin
          load      = 1'b1;
          load_data = acc;
          load_keep = keep_res;
          load_last = 1'b1;
        end
      end
      DONE: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Lane counter, accumulator and vertex count.
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      lane_cnt     <= '0;
      acc          <= '0;
      vertex_count <= '0;
    end else if ((state == IDLE) && ap_start) begin
      lane_cnt     <= '0;
      acc          <= '0;
      vertex_count <= '0;
    end else if (pop_id) begin
      vertex_count <= vertex_count + 32'd1;
      if (lane_cnt == LAST_LANE) begin
        // Full word has moved to the output register; restart with zeroed lanes.
        lane_cnt <= '0;
        acc      <= '0;
      end else begin
        lane_cnt <= lane_cnt + 1'b1;
        acc      <= acc_wr;
      end
    end
  end

  kernel_bc_vertex_packer_oreg #(
    .LANES (LANES)
  ) u_oreg (
    .clk       (ap_clk),
    .rst_n     (ap_rst_n),
    .load      (load),
    .load_data (load_data),
    .load_keep (load_keep),
    .load_last (load_last),
    .ready     (out_ready),
    .data      (out_data),
    .keep      (out_keep),
    .last      (out_last),
    .valid     (out_valid),
    .free      (oreg_free)
  );

endmodule
